// File: rtl/apb_pkg.sv
// Shared types and constants for the I2C subsystem APB requester.
package apb_pkg;

  // Default data path width, and the width of the response struct's rdata field
  localparam int unsigned DataW = 32;

  // Completer register map
  localparam logic [31:0] ADDR_TX_FIFO     = 32'd0;
  localparam logic [31:0] ADDR_RX_FIFO     = 32'd4;
  localparam logic [31:0] ADDR_I2C_CONFIG  = 32'd8;
  localparam logic [31:0] ADDR_I2C_TIMEOUT = 32'd12;

  // Requester transfer phases
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  // Result of one completed or aborted transfer
  typedef struct packed {
    logic [DataW-1:0] rdata;
    logic             err;
    logic             timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-cycle counter used to bound how long a transfer waits on PREADY.
module apb_wait_timer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [Width-1:0] Max = '1;

  logic [Width-1:0] count_q;
  logic [31:0]      count_ext;

  // Count enabled cycles since the last clear, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != Max)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_ext = 32'(count_q);

  // Flags that the next enabled cycle reaches the limit; a limit of 0 never expires
  assign expired = (Limit != 0) && ((count_ext + 32'd1) >= Limit);

endmodule

// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command stream into single APB transfers and
// returns read data, slave error and timeout status on a valid/ready response channel.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = DataW,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // A zero timeout still needs a legal one-bit counter
  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  apb_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  apb_rsp_t          rsp_q, rsp_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  apb_wait_timer #(
    .Width(CntW),
    .Limit(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // Next-state, command capture and response capture
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_d       = rsp_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // CMD_READY is high throughout IDLE, so CMD_VALID alone is the handshake
        if (CMD_VALID) begin
          write_d     = CMD_WRITE;
          addr_d      = CMD_ADDR;
          wdata_d     = CMD_WRITE ? CMD_WDATA : '0;
          timer_clear = 1'b1;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          rsp_d.rdata   = write_q ? '0 : PRDATA;
          rsp_d.err     = PSLVERR;
          rsp_d.timeout = 1'b0;
          state_d       = StResp;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            rsp_d.rdata   = '0;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
            state_d       = StResp;
          end
        end
      end
      StResp: begin
        if (RSP_READY) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured transfer/response registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  assign CMD_READY   = (state_q == StIdle);
  assign PSELx       = (state_q == StSetup) || (state_q == StAccess);
  assign PENABLE     = (state_q == StAccess);
  assign PWRITE      = write_q;
  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign RSP_VALID   = (state_q == StResp);
  assign RSP_RDATA   = rsp_q.rdata;
  assign RSP_ERR     = rsp_q.err;
  assign RSP_TIMEOUT = rsp_q.timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester with a scripted APB completer and response scoreboard.
module tb_apb_requester;
  import apb_pkg::*;

  localparam int unsigned TimeoutCyc = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp = 0;
  int n_fail = 0;
  apb_rsp_t sb[$];

  apb_requester #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_WRITE  (CMD_WRITE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  // Present a command, wait (bounded) for acceptance; returns in the SETUP cycle
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output bit ok);
    int n = 0;
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_WDATA = d;
    while (!CMD_READY && n < 20) begin
      cyc();
      n++;
    end
    ok = CMD_READY;
    cyc();
    // Scramble the command bus so the bench sees only captured values
    CMD_VALID = 1'b0;
    CMD_WRITE = ~w;
    CMD_ADDR  = 32'hFFFF_FFF0;
    CMD_WDATA = 32'hCAFE_F00D;
  endtask

  // Act as the completer from SETUP until RSP_VALID; PREADY rises on ACCESS cycle wait_n
  task automatic complete(input int wait_n, input logic [31:0] rdata, input logic slverr,
                          output int en_cycles, output bit stable, output bit got);
    logic [31:0] a0, d0;
    logic        w0;
    a0 = PADDR;
    d0 = PWDATA;
    w0 = PWRITE;
    en_cycles = 0;
    stable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (PSELx && (PADDR !== a0 || PWDATA !== d0 || PWRITE !== w0)) stable = 1'b0;
      if (RSP_VALID) begin
        got = 1'b1;
      end else if (PENABLE) begin
        if (en_cycles == wait_n) begin
          PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
        end else begin
          // Error and data while not ready must be ignored
          PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
        end
        en_cycles++;
        cyc();
      end else begin
        // SETUP: a ready pulse here must be ignored
        PREADY = 1'b1; PRDATA = 32'hBAD0_0BAD; PSLVERR = 1'b1;
        cyc();
      end
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    PRDATA = '0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", CMD_READY);
    end
    n_cmp++;
    if ({PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT});
    end
    n_cmp++;
    if (PADDR !== 32'h0 || PWDATA !== 32'h0 || RSP_RDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h wdata %h rdata %h want all 0", PADDR, PWDATA, RSP_RDATA);
    end
    PRESETn = 1'b1;
    cyc();
  endtask

  task automatic test_write_fast();
    bit ok, stable, got;
    int en;
    apb_rsp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
    issue(1'b1, ADDR_I2C_CONFIG, 32'h0000_1234, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL wr_accept: got 0 want 1"); end
    n_cmp++;
    if ({PSELx, PENABLE, CMD_READY} !== 3'b100) begin
      n_fail++; $display("FAIL wr_setup_phase: got %b want 100", {PSELx, PENABLE, CMD_READY});
    end
    n_cmp++;
    if (PWRITE !== 1'b1 || PADDR !== 32'd8 || PWDATA !== 32'h1234) begin
      n_fail++;
      $display("FAIL wr_bus: got w %b a %h d %h want 1 8 1234", PWRITE, PADDR, PWDATA);
    end
    complete(0, 32'h0, 1'b0, en, stable, got);
    n_cmp++;
    if (en !== 1) begin n_fail++; $display("FAIL wr_penable_cycles: got %0d want 1", en); end
    n_cmp++;
    if (!stable) begin n_fail++; $display("FAIL wr_bus_stable: got 0 want 1"); end
    n_cmp++;
    if (!got || PSELx !== 1'b0 || PENABLE !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp: got valid %b sel %b en %b want 1 0 0", got, PSELx, PENABLE);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {e.rdata, e.err, e.timeout}) begin
        n_fail++;
        $display("FAIL wr_rsp: got %h/%b/%b want %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                 e.rdata, e.err, e.timeout);
      end
    end
    RSP_READY = 1'b1;
    cyc();
    RSP_READY = 1'b0;
    n_cmp++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL wr_release: got valid %b ready %b want 0 1", RSP_VALID, CMD_READY);
    end
  endtask

  task automatic test_read_wait();
    bit ok, stable, got;
    int en;
    apb_rsp_t e;
    sb.push_back('{rdata: 32'hA5A5_0001, err: 1'b0, timeout: 1'b0});
    issue(1'b0, ADDR_RX_FIFO, 32'hFFFF_FFFF, ok);
    n_cmp++;
    if (!ok || PWDATA !== 32'h0 || PWRITE !== 1'b0 || PADDR !== 32'd4) begin
      n_fail++;
      $display("FAIL rd_setup: got ok %b w %b a %h d %h want 1 0 4 0", ok, PWRITE, PADDR, PWDATA);
    end
    complete(3, 32'hA5A5_0001, 1'b0, en, stable, got);
    n_cmp++;
    if (en !== 4) begin n_fail++; $display("FAIL rd_penable_cycles: got %0d want 4", en); end
    n_cmp++;
    if (!stable) begin n_fail++; $display("FAIL rd_bus_stable: got 0 want 1"); end
    n_cmp++;
    if (!got) begin
      n_fail++; $display("FAIL rd_resp: got no RSP_VALID want 1");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {e.rdata, e.err, e.timeout}) begin
        n_fail++;
        $display("FAIL rd_rsp: got %h/%b/%b want %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                 e.rdata, e.err, e.timeout);
      end
    end
    RSP_READY = 1'b1;
    cyc();
    RSP_READY = 1'b0;
  endtask

  task automatic test_slverr();
    bit ok, stable, got;
    int en;
    apb_rsp_t e;
    // Ready held high before the response exists
    RSP_READY = 1'b1;
    cyc();
    sb.push_back('{rdata: 32'h0, err: 1'b1, timeout: 1'b0});
    issue(1'b1, ADDR_TX_FIFO, 32'h0000_0055, ok);
    complete(0, 32'h1111_1111, 1'b1, en, stable, got);
    n_cmp++;
    if (!ok || !got) begin
      n_fail++; $display("FAIL err_resp: got ok %b valid %b want 1 1", ok, got);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {e.rdata, e.err, e.timeout}) begin
        n_fail++;
        $display("FAIL err_rsp: got %h/%b/%b want %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                 e.rdata, e.err, e.timeout);
      end
    end
    cyc();
    RSP_READY = 1'b0;
    n_cmp++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL err_release: got valid %b ready %b want 0 1", RSP_VALID, CMD_READY);
    end
  endtask

  task automatic test_timeout();
    bit ok, stable, got;
    int en;
    apb_rsp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b1, timeout: 1'b1});
    issue(1'b0, ADDR_I2C_TIMEOUT, 32'h0, ok);
    complete(1000, 32'h7777_7777, 1'b0, en, stable, got);
    n_cmp++;
    if (en !== int'(TimeoutCyc)) begin
      n_fail++; $display("FAIL to_access_cycles: got %0d want %0d", en, TimeoutCyc);
    end
    n_cmp++;
    if (!got || PSELx !== 1'b0 || PENABLE !== 1'b0) begin
      n_fail++; $display("FAIL to_abort: got valid %b sel %b en %b want 1 0 0", got, PSELx, PENABLE);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {e.rdata, e.err, e.timeout}) begin
        n_fail++;
        $display("FAIL to_rsp: got %h/%b/%b want %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                 e.rdata, e.err, e.timeout);
      end
    end
    RSP_READY = 1'b1;
    cyc();
    RSP_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok, stable, got;
    int en;
    apb_rsp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
    issue(1'b1, ADDR_I2C_CONFIG, 32'h0000_00A1, ok);
    complete(0, 32'h0, 1'b0, en, stable, got);
    // Second command waits while the first response is held
    sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = ADDR_I2C_TIMEOUT;
    CMD_WDATA = 32'h0000_00B2;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (CMD_READY !== 1'b0 || RSP_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: got ready %b valid %b want 0 1", i, CMD_READY, RSP_VALID);
      end
      cyc();
    end
    e = sb.pop_front();
    n_cmp++;
    if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {e.rdata, e.err, e.timeout}) begin
      n_fail++;
      $display("FAIL b2b_rsp1: got %h/%b/%b want %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
               e.rdata, e.err, e.timeout);
    end
    RSP_READY = 1'b1;
    cyc();
    RSP_READY = 1'b0;
    n_cmp++;
    if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got ready %b valid %b want 1 0", CMD_READY, RSP_VALID);
    end
    cyc();
    CMD_VALID = 1'b0;
    n_cmp++;
    if (PSELx !== 1'b1 || PADDR !== 32'd12 || PWDATA !== 32'hB2) begin
      n_fail++; $display("FAIL b2b_setup2: got sel %b a %h d %h want 1 c b2", PSELx, PADDR, PWDATA);
    end
    complete(0, 32'h0, 1'b0, en, stable, got);
    n_cmp++;
    if (!got) begin
      n_fail++; $display("FAIL b2b_resp2: got no RSP_VALID want 1");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {e.rdata, e.err, e.timeout}) begin
        n_fail++;
        $display("FAIL b2b_rsp2: got %h/%b/%b want %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                 e.rdata, e.err, e.timeout);
      end
    end
    RSP_READY = 1'b1;
    cyc();
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset_access();
    bit ok;
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, timeout: 1'b0});
    issue(1'b0, ADDR_RX_FIFO, 32'h0, ok);
    PREADY = 1'b0;
    cyc();
    n_cmp++;
    if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL rst_in_access: got %b want 1", PENABLE); end
    PRESETn = 1'b0;
    PREADY  = 1'b1;
    PRDATA  = 32'h1234_5678;
    cyc();
    // The aborted transfer owes no response
    sb.delete();
    n_cmp++;
    if ({PSELx, PENABLE, RSP_VALID, CMD_READY} !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_abort: got %b want 0001", {PSELx, PENABLE, RSP_VALID, CMD_READY});
    end
    PRESETn = 1'b1;
    PREADY  = 1'b0;
    PRDATA  = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_no_rsp[%0d]: got valid %b rdata %h want 0 0", i, RSP_VALID, RSP_RDATA);
      end
    end
  endtask

  initial begin
    PRESETn   = 1'b0;
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;
    RSP_READY = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    test_reset();
    test_write_fast();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_access();

    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
